// File: rtl/vga_text_writer_pkg.sv
// Shared constants and types for the vga_text_writer character front end.
//   TXT_COLS / TXT_ROWS : default screen geometry in characters (80x32)
//   ASCII_*             : control codes the writer interprets
//   txt_state_t         : writer FSM state encoding
//   is_printable()      : true for bytes that are stored as glyphs
// Optional build macro: VGA_TEXT_CLRLINE_EN adds the CLRLINE state.
package vga_text_writer_pkg;

    localparam int TXT_COLS = 80;
    localparam int TXT_ROWS = 32;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

`ifdef VGA_TEXT_CLRLINE_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_CLEAR   = 2'd2,
        ST_CLRLINE = 2'd3
    } txt_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_CLEAR   = 2'd2
    } txt_state_t;
`endif

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/vga_text_writer_txt_fifo.sv
// txt_fifo: synchronous FIFO buffering CPU bytes ahead of the text writer FSM.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, din       : write din when push and not full (ignored when full)
//   pop             : advance read pointer when not empty
//   dout            : head entry, valid while !empty (show-ahead)
//   full, empty     : occupancy flags
// Parameters: WIDTH (entry bits), DEPTH (entries, power of two, >= 2).
module vga_text_writer_txt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; contents are only read behind the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_text_writer.sv
// vga_text_writer: turns a CPU byte stream into single-cycle writes on the
// vga_controller ascii RAM port, keeping an 80x32 text cursor.
// Ports:
//   clk, rst          : 100 MHz clock, asynchronous active-high reset
//   cpu_we, cpu_data  : push a byte into the input FIFO
//   cpu_full          : FIFO full, pushes are dropped while high
//   busy              : FSM not idle or FIFO non-empty
//   waddr, wdata      : registered cell index (row*COLS+col) and code
//   sel_rw            : one-cycle write strobe qualifying waddr/wdata
//   cur_row, cur_col  : current cursor
// Build macro: VGA_TEXT_CLRLINE_EN blanks the destination row on every row
// advance (CLRLINE state); without it the old row text is left in place.
//
// state   | meaning
// IDLE    | waiting; pops the FIFO head into cmd_q when available
// EXEC    | acts on cmd_q for one cycle (write, cursor move, or FF)
// CLEAR   | writes space to every cell, then homes the cursor
// CLRLINE | writes space across the new cursor row (macro builds only)
module vga_text_writer
    import vga_text_writer_pkg::*;
#(
    parameter int COLS       = TXT_COLS,
    parameter int ROWS       = TXT_ROWS,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_data,
    output logic        cpu_full,
    output logic        busy,
    output logic [31:0] waddr,
    output logic [7:0]  wdata,
    output logic        sel_rw,
    output logic [4:0]  cur_row,
    output logic [6:0]  cur_col
);

    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = $clog2(CELLS);

    txt_state_t       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [4:0]       row_q, row_d;
    logic [6:0]       col_q, col_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             sel_q, sel_d;
    logic             row_adv;
    logic [4:0]       row_inc;

    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [7:0]       fifo_dout;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [4:0] r,
                                                  input logic [IDX_W-1:0] c);
        return IDX_W'(r) * IDX_W'(COLS) + c;
    endfunction

    vga_text_writer_txt_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_txt_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cpu_we),
        .pop   (fifo_pop),
        .din   (cpu_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign row_inc = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        col_d    = col_q;
        cmd_d    = cmd_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        sel_d    = 1'b0;
        fifo_pop = 1'b0;
        row_adv  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_dout;
                    state_d  = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = ST_IDLE;
                if (is_printable(cmd_q)) begin
                    sel_d   = 1'b1;
                    waddr_d = 32'(cell_idx(row_q, IDX_W'(col_q)));
                    wdata_d = cmd_q;
                    if (col_q == 7'(COLS - 1)) begin
                        col_d   = 7'd0;
                        row_adv = 1'b1;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end else begin
                    case (cmd_q)
                        ASCII_LF: begin
                            col_d   = 7'd0;
                            row_adv = 1'b1;
                        end
                        ASCII_CR: col_d = 7'd0;
                        ASCII_BS: begin
                            if (col_q != 7'd0) begin
                                col_d   = col_q - 7'd1;
                                sel_d   = 1'b1;
                                waddr_d = 32'(cell_idx(row_q, IDX_W'(col_q - 7'd1)));
                                wdata_d = ASCII_SPACE;
                            end
                        end
                        ASCII_FF: begin
                            state_d = ST_CLEAR;
                            cnt_d   = '0;
                        end
                        default: ;
                    endcase
                end
                if (row_adv) begin
                    row_d = row_inc;
`ifdef VGA_TEXT_CLRLINE_EN
                    state_d = ST_CLRLINE;
                    cnt_d   = '0;
`endif
                end
            end

            ST_CLEAR: begin
                sel_d   = 1'b1;
                waddr_d = 32'(cnt_q);
                wdata_d = ASCII_SPACE;
                if (cnt_q == IDX_W'(CELLS - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    row_d   = 5'd0;
                    col_d   = 7'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef VGA_TEXT_CLRLINE_EN
            // row_q already holds the destination row when we get here.
            ST_CLRLINE: begin
                sel_d   = 1'b1;
                waddr_d = 32'(cell_idx(row_q, cnt_q));
                wdata_d = ASCII_SPACE;
                if (cnt_q == IDX_W'(COLS - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            row_q   <= 5'd0;
            col_q   <= 7'd0;
            cmd_q   <= 8'd0;
            waddr_q <= 32'd0;
            wdata_q <= 8'd0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cmd_q   <= cmd_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
        end
    end

    assign cpu_full = fifo_full;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign sel_rw   = sel_q;
    assign cur_row  = row_q;
    assign cur_col  = col_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Self-checking bench for vga_text_writer. A screen-level model predicts the
// ordered list of (address, code) writes and the cursor for every byte sent;
// a monitor matches each sel_rw strobe against that list.
module tb_vga_text_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 32;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_we;
    logic [7:0]  cpu_data;
    logic        cpu_full;
    logic        busy;
    logic [31:0] waddr;
    logic [7:0]  wdata;
    logic        sel_rw;
    logic [4:0]  cur_row;
    logic [6:0]  cur_col;

    int n_cmp = 0;
    int n_err = 0;
    int n_strobe = 0;
    int n_exp_total = 0;

    int          m_row;
    int          m_col;
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_data[$];

    always #5 clk = ~clk;

    vga_text_writer dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_we   (cpu_we),
        .cpu_data (cpu_data),
        .cpu_full (cpu_full),
        .busy     (busy),
        .waddr    (waddr),
        .wdata    (wdata),
        .sel_rw   (sel_rw),
        .cur_row  (cur_row),
        .cur_col  (cur_col)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void exp_write(input int a, input logic [7:0] d);
        exp_addr.push_back(32'(a));
        exp_data.push_back(d);
        n_exp_total++;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < CELLS; i++) exp_write(i, 8'h20);
        m_row = 0;
        m_col = 0;
    endfunction

    function automatic void model_next_row();
        m_row = (m_row + 1) % ROWS;
`ifdef VGA_TEXT_CLRLINE_EN
        for (int c = 0; c < COLS; c++) exp_write(m_row * COLS + c, 8'h20);
`endif
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_write(m_row * COLS + m_col, b);
            if (m_col == COLS - 1) begin
                m_col = 0;
                model_next_row();
            end else begin
                m_col++;
            end
        end else if (b == 8'h0A) begin
            m_col = 0;
            model_next_row();
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                exp_write(m_row * COLS + m_col, 8'h20);
            end
        end else if (b == 8'h0C) begin
            model_clear();
        end
    endfunction

    // ---------------- strobe monitor ----------------
    always @(negedge clk) begin
        if (!rst && sel_rw) begin
            n_strobe++;
            if (exp_addr.size() == 0) begin
                chk("extra_strobe", waddr, 32'hFFFF_FFFF);
            end else begin
                chk("waddr", waddr, exp_addr.pop_front());
                chk("wdata", 32'(wdata), 32'(exp_data.pop_front()));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (cpu_full && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (cpu_full) chk("full_wait_timeout", 32'(cpu_full), 32'd0);
        cpu_we   = 1'b1;
        cpu_data = b;
        model_byte(b);
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({tag, "_timeout"}, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_row"}, 32'(cur_row), 32'(m_row));
        chk({tag, "_col"}, 32'(cur_col), 32'(m_col));
        chk({tag, "_pending"}, 32'(exp_addr.size()), 32'd0);
    endtask

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(32, 126));
    endfunction

    function automatic logic [7:0] rand_byte();
        int r;
        logic [7:0] odd [5];
        odd[0] = 8'h00; odd[1] = 8'h7F; odd[2] = 8'h1B; odd[3] = 8'h09; odd[4] = 8'hFF;
        r = $urandom_range(0, 99);
        if (r < 70) return rand_print();
        if (r < 78) return 8'h0A;
        if (r < 84) return 8'h0D;
        if (r < 94) return 8'h08;
        return odd[$urandom_range(0, 4)];
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        rst      = 1'b1;
        cpu_we   = 1'b0;
        cpu_data = 8'h00;
        m_row    = 0;
        m_col    = 0;
        repeat (3) @(negedge clk);

        chk("rst_sel_rw", 32'(sel_rw), 32'd0);
        chk("rst_waddr", waddr, 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_row", 32'(cur_row), 32'd0);
        chk("rst_col", 32'(cur_col), 32'd0);
        chk("rst_full", 32'(cpu_full), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        model_clear();
        rst = 1'b0;
        wait_idle("clear");
        check_state("clear");
        chk("clear_strobes", 32'(n_strobe), 32'(CELLS));
        chk("clear_busy", 32'(busy), 32'd0);

        push_byte(8'h41);
        push_byte(8'h42);
        wait_idle("ab");
        check_state("ab");
        chk("ab_col", 32'(cur_col), 32'd2);

        // Walk to (3,79) and print across the right edge.
        push_byte(8'h0D);
        repeat (3) push_byte(8'h0A);
        for (int i = 0; i < COLS - 1; i++) push_byte(rand_print());
        wait_idle("to_3_79");
        check_state("at_3_79");
        push_byte(8'h5A);
        wait_idle("wrap");
        check_state("wrap");
        chk("wrap_row", 32'(cur_row), 32'd4);

        // Backspace at column 0 and mid-row, after a form feed homes.
        push_byte(8'h0C);
        push_byte(8'h0A);
        push_byte(8'h0A);
        push_byte(8'h08);
        wait_idle("bs0");
        check_state("bs0");
        for (int i = 0; i < 7; i++) push_byte(rand_print());
        push_byte(8'h08);
        wait_idle("bs7");
        check_state("bs7");
        chk("bs7_col", 32'(cur_col), 32'd6);

        // Line feed from the last row wraps to row 0.
        push_byte(8'h0D);
        for (int i = 0; i < 29; i++) push_byte(8'h0A);
        for (int i = 0; i < 5; i++) push_byte(rand_print());
        wait_idle("to_31_5");
        check_state("at_31_5");
        push_byte(8'h0A);
        wait_idle("lf_wrap");
        check_state("lf_wrap");

        // Burst of 9 during a clear: the 9th is dropped.
        push_byte(8'h0C);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            if (i == 7) chk("full_after_7", 32'(cpu_full), 32'd0);
            if (i == 8) chk("full_after_8", 32'(cpu_full), 32'd1);
            cpu_we   = 1'b1;
            cpu_data = rand_print();
            if (i < 8) model_byte(cpu_data);
            @(negedge clk);
        end
        cpu_we = 1'b0;
        wait_idle("burst");
        check_state("burst");

        // Random traffic with random gaps.
        for (int i = 0; i < 300; i++) begin
            push_byte(rand_byte());
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle("random");
        check_state("random");
        chk("total_strobes", 32'(n_strobe), 32'(n_exp_total));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
